// File: rtl/demodchest_pkg.sv
// demodchest_pkg: register map, FSM state encoding and status word layout
// shared by the demodchest run controller and its framer.
package demodchest_pkg;

  localparam logic [19:0] ADDR_CTRL      = 20'h00;
  localparam logic [19:0] ADDR_SPP       = 20'h04;
  localparam logic [19:0] ADDR_NUM_PKTS  = 20'h08;
  localparam logic [19:0] ADDR_STATUS    = 20'h0C;
  localparam logic [19:0] ADDR_PKT_COUNT = 20'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [21:0] rsvd_hi;
    logic        stop_pend;
    logic        spp_err;
    logic [5:0]  rsvd_lo;
    logic [1:0]  state;
  } status_t;

endpackage

// File: rtl/demodchest_ctrl_framer.sv
// demodchest_framer: sample/packet counters and tlast, teob, tlength
// decode for the re-framed output stream.
module demodchest_framer
  import demodchest_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] spp,
  input  logic [31:0] num_pkts,
  input  logic        stop_pend,
  input  logic        out_valid,
  input  logic        out_ready,
  output logic        tlast,
  output logic        teob,
  output logic [15:0] tlength,
  output logic [31:0] pkt_count,
  output logic        final_done
);

  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pkt_q, pkt_d;
  logic        held_q, held_d;
  logic        eob_q, eob_d;
  logic        last_pkt, beat;

  always_comb begin
    beat     = out_valid & out_ready;
    last_pkt = ((num_pkts != '0) && (pkt_q == num_pkts - 32'd1))
               || stop_pend;
    tlast    = (cnt_q == spp - 16'd1);
    // a stalled beat keeps the teob it was first presented with
    teob       = tlast & (held_q ? eob_q : last_pkt);
    final_done = beat & teob;
    tlength    = 16'(32'(spp) * (OUT_W / 8));
    cnt_d  = cnt_q;
    pkt_d  = pkt_q;
    held_d = out_valid & ~out_ready;
    eob_d  = teob;
    if (clr) begin
      cnt_d  = '0;
      pkt_d  = '0;
      held_d = 1'b0;
    end else if (beat) begin
      cnt_d = tlast ? '0 : cnt_q + 16'd1;
      if (tlast && (pkt_q != '1)) pkt_d = pkt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pkt_q  <= '0;
      held_q <= 1'b0;
      eob_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pkt_q  <= pkt_d;
      held_q <= held_d;
      eob_q  <= eob_d;
    end
  end

  assign pkt_count = pkt_q;

endmodule

// File: rtl/demodchest_ctrl.sv
// demodchest_ctrl: CtrlPort registers, run FSM, stream gating and flush.
// Optional DEMODCHEST_CTRL_TIMESTAMP_EN adds first-packet timestamping.
module demodchest_ctrl
  import demodchest_pkg::*;
#(
  parameter int IN_W         = 32,
  parameter int OUT_W        = 32,
  parameter int SPP_DEFAULT  = 256,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic             axis_data_clk,
  input  logic             axis_data_rst,
  input  logic             s_ctrlport_req_wr,
  input  logic             s_ctrlport_req_rd,
  input  logic [19:0]      s_ctrlport_req_addr,
  input  logic [31:0]      s_ctrlport_req_data,
  output logic             s_ctrlport_resp_ack,
  output logic [31:0]      s_ctrlport_resp_data,
  input  logic [IN_W-1:0]  s_in_axis_tdata,
  input  logic             s_in_axis_tvalid,
  output logic             s_in_axis_tready,
  input  logic [63:0]      s_in_axis_ttimestamp,
  input  logic             s_in_axis_thas_time,
  output logic [IN_W-1:0]  m_ip_axis_tdata,
  output logic             m_ip_axis_tvalid,
  input  logic             m_ip_axis_tready,
  input  logic [OUT_W-1:0] s_ip_axis_tdata,
  input  logic             s_ip_axis_tvalid,
  output logic             s_ip_axis_tready,
  output logic [OUT_W-1:0] m_out_axis_tdata,
  output logic             m_out_axis_tvalid,
  input  logic             m_out_axis_tready,
  output logic             m_out_axis_tlast,
  output logic             m_out_axis_teob,
  output logic             m_out_axis_teov,
  output logic             m_out_axis_thas_time,
  output logic             m_out_axis_tkeep,
  output logic [15:0]      m_out_axis_tlength,
  output logic [63:0]      m_out_axis_ttimestamp,
  output logic [1:0]       status_state
);

  localparam int FW = $clog2(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] spp_q, spp_d, spp_run_q, spp_run_d;
  logic [31:0] num_q, num_d, num_run_q, num_run_d;
  logic        err_q, err_d, pend_q, pend_d;
  logic        start_q, start_d, stop_q, stop_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic        wr_ctrl, go, halt, run, flush;
  logic [31:0] pkt_count;
  logic        final_done;
  status_t     st;

  assign run   = (state_q == ST_RUN);
  assign flush = (state_q == ST_FLUSH);

  always_comb begin
    wr_ctrl = s_ctrlport_req_wr && (s_ctrlport_req_addr == ADDR_CTRL);
    start_d = wr_ctrl && s_ctrlport_req_data[CTRL_START];
    stop_d  = wr_ctrl && s_ctrlport_req_data[CTRL_STOP];
    go      = start_q && (state_q == ST_IDLE);
    halt    = stop_q && run;
    spp_d   = spp_q;
    num_d   = num_q;
    err_d   = err_q & ~go;
    if (s_ctrlport_req_wr) begin
      if (s_ctrlport_req_addr == ADDR_SPP) begin
        if (s_ctrlport_req_data[15:0] == '0) err_d = 1'b1;
        else spp_d = s_ctrlport_req_data[15:0];
      end
      if (s_ctrlport_req_addr == ADDR_NUM_PKTS)
        num_d = s_ctrlport_req_data;
    end
    st           = '0;
    st.state     = state_q;
    st.spp_err   = err_q;
    st.stop_pend = pend_q;
    unique case (1'b1)
      s_ctrlport_req_addr == ADDR_SPP:       rd_val = {16'd0, spp_q};
      s_ctrlport_req_addr == ADDR_NUM_PKTS:  rd_val = num_q;
      s_ctrlport_req_addr == ADDR_STATUS:    rd_val = st;
      s_ctrlport_req_addr == ADDR_PKT_COUNT: rd_val = pkt_count;
      default:                               rd_val = '0;
    endcase
    ack_d   = s_ctrlport_req_wr | s_ctrlport_req_rd;
    rdata_d = s_ctrlport_req_rd ? rd_val : '0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    spp_run_d = spp_run_q;
    num_run_d = num_run_q;
    pend_d    = pend_q;
    unique case (state_q)
      ST_IDLE: if (go) begin
        state_d   = ST_RUN;
        spp_run_d = spp_q;
        num_run_d = num_q;
        pend_d    = 1'b0;
      end
      ST_RUN: begin
        if (halt) pend_d = 1'b1;
        if (final_done) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        if (s_ip_axis_tvalid) fcnt_d = '0;
        else if (fcnt_q == FW'(FLUSH_CYCLES - 1)) state_d = ST_IDLE;
        else fcnt_d = fcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state_q   <= ST_IDLE;
      spp_q     <= 16'(SPP_DEFAULT);
      spp_run_q <= 16'(SPP_DEFAULT);
      num_q     <= '0;
      num_run_q <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      fcnt_q    <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      spp_q     <= spp_d;
      spp_run_q <= spp_run_d;
      num_q     <= num_d;
      num_run_q <= num_run_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      fcnt_q    <= fcnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  demodchest_framer #(.OUT_W(OUT_W)) u_framer (
    .clk        (axis_data_clk),
    .rst        (axis_data_rst),
    .clr        (go),
    .spp        (spp_run_q),
    .num_pkts   (num_run_q),
    .stop_pend  (pend_q),
    .out_valid  (m_out_axis_tvalid),
    .out_ready  (m_out_axis_tready),
    .tlast      (m_out_axis_tlast),
    .teob       (m_out_axis_teob),
    .tlength    (m_out_axis_tlength),
    .pkt_count  (pkt_count),
    .final_done (final_done)
  );

  assign s_ctrlport_resp_ack  = ack_q;
  assign s_ctrlport_resp_data = rdata_q;
  assign status_state         = state_q;

  assign m_ip_axis_tdata   = s_in_axis_tdata;
  assign m_ip_axis_tvalid  = run & s_in_axis_tvalid;
  assign s_in_axis_tready  = run & m_ip_axis_tready;
  assign m_out_axis_tdata  = s_ip_axis_tdata;
  assign m_out_axis_tvalid = run & s_ip_axis_tvalid;
  assign s_ip_axis_tready  = (run & m_out_axis_tready) | flush;
  assign m_out_axis_teov   = 1'b0;
  assign m_out_axis_tkeep  = 1'b1;

`ifdef DEMODCHEST_CTRL_TIMESTAMP_EN
  logic [63:0] ts_q, ts_d;
  logic        ht_q, ht_d, cap_q, cap_d;

  always_comb begin
    ts_d  = ts_q;
    ht_d  = ht_q;
    cap_d = cap_q;
    if (go) begin
      ht_d  = 1'b0;
      cap_d = 1'b0;
    end else if (s_in_axis_tvalid && s_in_axis_tready && !cap_q) begin
      ts_d  = s_in_axis_ttimestamp;
      ht_d  = s_in_axis_thas_time;
      cap_d = 1'b1;
    end
  end

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      ts_q  <= '0;
      ht_q  <= 1'b0;
      cap_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      ht_q  <= ht_d;
      cap_q <= cap_d;
    end
  end

  assign m_out_axis_ttimestamp = ts_q;
  assign m_out_axis_thas_time  = ht_q && (pkt_count == '0);
`else
  logic unused_ts;
  assign unused_ts = ^{s_in_axis_ttimestamp, s_in_axis_thas_time};
  assign m_out_axis_ttimestamp = '0;
  assign m_out_axis_thas_time  = 1'b0;
`endif

endmodule

// File: tb/tb_demodchest_ctrl.sv
// tb_demodchest_ctrl: directed bench for the demodchest run controller.
// Drives the shell and IP sides directly with hand-computed expectations.
module tb_demodchest_ctrl;
  import demodchest_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_wr, req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tready;
  logic [63:0] in_ts;
  logic        in_ht;
  logic [31:0] ip_tdata;
  logic        ip_tvalid, ip_tready;
  logic [31:0] ipo_tdata;
  logic        ipo_tvalid, ipo_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid, out_tready;
  logic        out_tlast, out_teob, out_teov, out_ht, out_tkeep;
  logic [15:0] out_tlength;
  logic [63:0] out_ts;
  logic [1:0]  st_state;

  int n_cmp = 0;
  int n_bad = 0;

  int          nb, data_bad, stab_err, flush_idle, in_rdy_flush;
  int          first_run_c;
  logic [31:0] last_mask, eob_mask, ht_mask;
  logic [15:0] lens [32];
  logic [63:0] ts0;

  demodchest_ctrl dut (
    .axis_data_clk        (clk),
    .axis_data_rst        (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .s_in_axis_tdata      (in_tdata),
    .s_in_axis_tvalid     (in_tvalid),
    .s_in_axis_tready     (in_tready),
    .s_in_axis_ttimestamp (in_ts),
    .s_in_axis_thas_time  (in_ht),
    .m_ip_axis_tdata      (ip_tdata),
    .m_ip_axis_tvalid     (ip_tvalid),
    .m_ip_axis_tready     (ip_tready),
    .s_ip_axis_tdata      (ipo_tdata),
    .s_ip_axis_tvalid     (ipo_tvalid),
    .s_ip_axis_tready     (ipo_tready),
    .m_out_axis_tdata     (out_tdata),
    .m_out_axis_tvalid    (out_tvalid),
    .m_out_axis_tready    (out_tready),
    .m_out_axis_tlast     (out_tlast),
    .m_out_axis_teob      (out_teob),
    .m_out_axis_teov      (out_teov),
    .m_out_axis_thas_time (out_ht),
    .m_out_axis_tkeep     (out_tkeep),
    .m_out_axis_tlength   (out_tlength),
    .m_out_axis_ttimestamp(out_ts),
    .status_state         (st_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cp_write(input logic [19:0] a, input logic [31:0] d);
    req_wr   = 1'b1;
    req_addr = a;
    req_data = d;
    tick();
    req_wr = 1'b0;
  endtask

  task automatic cp_read(input logic [19:0] a, output logic [31:0] d);
    req_rd   = 1'b1;
    req_addr = a;
    tick();
    req_rd = 1'b0;
    d = resp_data;
  endtask

  // shared stimulus driver; records beats for the calling test to judge
  task automatic drive_run(input int ncyc, input int vs, input int ve,
                           input int rdy_pct, input int stop_beat);
    logic h, hl, he;
    nb = 0; data_bad = 0; stab_err = 0; flush_idle = 0;
    in_rdy_flush = 0; first_run_c = -1;
    last_mask = '0; eob_mask = '0; ht_mask = '0; ts0 = '0;
    h = 1'b0; hl = 1'b0; he = 1'b0;
    in_tvalid = 1'b1;
    ip_tready = 1'b1;
    in_ht     = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      req_wr     = 1'b0;
      in_ts      = (c <= 1) ? 64'h1000 : 64'h2000;
      ipo_tvalid = (c >= vs) && (c < ve);
      ipo_tdata  = 32'h1000 + 32'(nb);
      out_tready = (int'($urandom_range(0, 99)) < rdy_pct);
      #1;
      if (first_run_c < 0 && st_state == 2'd1) first_run_c = c;
      if (h && out_tvalid && (out_tlast !== hl || out_teob !== he))
        stab_err++;
      if (out_tvalid && out_tready) begin
        if (nb < 32) begin
          last_mask[nb] = out_tlast;
          eob_mask[nb]  = out_teob;
          ht_mask[nb]   = out_ht;
          lens[nb]      = out_tlength;
          if (nb == 0) ts0 = out_ts;
          if (out_tdata !== 32'h1000 + 32'(nb)) data_bad++;
        end
        nb++;
        h = 1'b0;
        if (nb == stop_beat) begin
          req_wr   = 1'b1;
          req_addr = ADDR_CTRL;
          req_data = 32'h2;
        end
      end else begin
        h  = out_tvalid;
        hl = out_tlast;
        he = out_teob;
      end
      if (st_state == 2'd2 && !ipo_tvalid) flush_idle++;
      if (st_state == 2'd2 && in_tready) in_rdy_flush++;
      tick();
    end
    req_wr     = 1'b0;
    ipo_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_tvalid = 1'b1; ip_tready = 1'b1;
    ipo_tvalid = 1'b1; out_tready = 1'b1;
    #1;
    n_cmp++;
    if ({in_tready, ip_tvalid, ipo_tready, out_tvalid, resp_ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_handshakes got %b want 00000",
               {in_tready, ip_tvalid, ipo_tready, out_tvalid, resp_ack});
    end
    n_cmp++;
    if ({resp_data, out_ts, out_ht, st_state} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs data=%h ts=%h ht=%b st=%0d want all 0",
               resp_data, out_ts, out_ht, st_state);
    end
    ipo_tvalid = 1'b0;
    tick();
    cp_read(ADDR_NUM_PKTS, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_bad++; $display("FAIL reset_num_pkts got %h want 0", d);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    req_rd = 1'b1; req_addr = ADDR_SPP;
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if (resp_ack !== 1'b1 || resp_data !== 32'd256) begin
      n_bad++;
      $display("FAIL regs_rd_ack ack=%b data=%h want 1/100", resp_ack, resp_data);
    end
    tick();
    n_cmp++;
    if (resp_ack !== 1'b0 || resp_data !== 32'd0) begin
      n_bad++;
      $display("FAIL regs_ack_drop ack=%b data=%h want 0/0", resp_ack, resp_data);
    end
    cp_write(ADDR_NUM_PKTS, 32'd5);
    n_cmp++;
    if (resp_ack !== 1'b1) begin
      n_bad++; $display("FAIL regs_wr_ack got %b want 1", resp_ack);
    end
    cp_read(ADDR_NUM_PKTS, d);
    n_cmp++;
    if (d !== 32'd5) begin
      n_bad++; $display("FAIL regs_num_rb got %h want 5", d);
    end
    cp_write(20'h40, 32'hDEAD_BEEF);
    cp_write(ADDR_STATUS, 32'hFFFF_FFFF);
    cp_read(20'h40, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_bad++; $display("FAIL regs_unmapped got %h want 0", d);
    end
    cp_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_bad++; $display("FAIL regs_status_ro got %h want 0", d);
    end
  endtask

  task automatic test_spp_err();
    logic [31:0] d;
    cp_write(ADDR_SPP, 32'd0);
    cp_read(ADDR_SPP, d);
    n_cmp++;
    if (d !== 32'd256) begin
      n_bad++; $display("FAIL spp0_readback got %h want 100", d);
    end
    cp_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'h100) begin
      n_bad++; $display("FAIL spp0_status got %h want 100", d);
    end
  endtask

  task automatic test_frames();
    logic [31:0] d;
    int lb;
    cp_write(ADDR_SPP, 32'd4);
    cp_write(ADDR_NUM_PKTS, 32'd3);
    cp_write(ADDR_CTRL, 32'h1);
    n_cmp++;
    if (st_state !== 2'd0) begin
      n_bad++; $display("FAIL frames_ack_state got %0d want 0", st_state);
    end
    drive_run(110, 3, 30, 100, 0);
    n_cmp++;
    if (first_run_c !== 1) begin
      n_bad++; $display("FAIL frames_run_cycle got %0d want 1", first_run_c);
    end
    n_cmp++;
    if (nb !== 12) begin
      n_bad++; $display("FAIL frames_beats got %0d want 12", nb);
    end
    n_cmp++;
    if (last_mask !== 32'h888) begin
      n_bad++; $display("FAIL frames_tlast got %h want 888", last_mask);
    end
    n_cmp++;
    if (eob_mask !== 32'h800) begin
      n_bad++; $display("FAIL frames_teob got %h want 800", eob_mask);
    end
    lb = 0;
    for (int i = 0; i < 12 && i < nb; i++) if (lens[i] !== 16'd16) lb++;
    n_cmp++;
    if (lb !== 0) begin
      n_bad++; $display("FAIL frames_tlength got %0d bad beats want 0", lb);
    end
    n_cmp++;
    if (data_bad !== 0) begin
      n_bad++; $display("FAIL frames_data got %0d bad beats want 0", data_bad);
    end
    n_cmp++;
    if (flush_idle !== 64) begin
      n_bad++; $display("FAIL frames_flush_len got %0d want 64", flush_idle);
    end
    n_cmp++;
    if (st_state !== 2'd0) begin
      n_bad++; $display("FAIL frames_end_state got %0d want 0", st_state);
    end
    cp_read(ADDR_PKT_COUNT, d);
    n_cmp++;
    if (d !== 32'd3) begin
      n_bad++; $display("FAIL frames_pkt_count got %0d want 3", d);
    end
    cp_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++; $display("FAIL frames_status got %h want 0", d);
    end
`ifdef DEMODCHEST_CTRL_TIMESTAMP_EN
    n_cmp++;
    if (ts0 !== 64'h1000 || ht_mask[0] !== 1'b1) begin
      n_bad++; $display("FAIL ts_first got %h/%b want 1000/1", ts0, ht_mask[0]);
    end
    n_cmp++;
    if (ht_mask[4] !== 1'b0) begin
      n_bad++; $display("FAIL ts_second got %b want 0", ht_mask[4]);
    end
`else
    n_cmp++;
    if (ts0 !== 64'h0 || ht_mask !== 32'h0) begin
      n_bad++; $display("FAIL ts_off got %h/%h want 0/0", ts0, ht_mask);
    end
`endif
  endtask

  task automatic test_stop();
    logic [31:0] d;
    cp_write(ADDR_SPP, 32'd8);
    cp_write(ADDR_NUM_PKTS, 32'd0);
    cp_write(ADDR_CTRL, 32'h1);
    drive_run(110, 3, 30, 100, 5);
    n_cmp++;
    if (nb !== 8) begin
      n_bad++; $display("FAIL stop_beats got %0d want 8", nb);
    end
    n_cmp++;
    if (last_mask !== 32'h80 || eob_mask !== 32'h80) begin
      n_bad++;
      $display("FAIL stop_marks last=%h eob=%h want 80/80", last_mask, eob_mask);
    end
    n_cmp++;
    if (in_rdy_flush !== 0) begin
      n_bad++; $display("FAIL stop_in_ready got %0d want 0", in_rdy_flush);
    end
    n_cmp++;
    if (st_state !== 2'd0) begin
      n_bad++; $display("FAIL stop_end_state got %0d want 0", st_state);
    end
    cp_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'h200) begin
      n_bad++; $display("FAIL stop_status got %h want 200", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    cp_write(ADDR_SPP, 32'd4);
    cp_write(ADDR_NUM_PKTS, 32'd4);
    cp_write(ADDR_CTRL, 32'h1);
    drive_run(180, 3, 90, 50, 0);
    n_cmp++;
    if (nb !== 16 || data_bad !== 0) begin
      n_bad++; $display("FAIL bp_beats got %0d/%0d want 16/0", nb, data_bad);
    end
    n_cmp++;
    if (last_mask !== 32'h8888 || eob_mask !== 32'h8000) begin
      n_bad++;
      $display("FAIL bp_marks last=%h eob=%h want 8888/8000", last_mask, eob_mask);
    end
    n_cmp++;
    if (stab_err !== 0) begin
      n_bad++; $display("FAIL bp_stable got %0d changes want 0", stab_err);
    end
    n_cmp++;
    if (st_state !== 2'd0) begin
      n_bad++; $display("FAIL bp_end_state got %0d want 0", st_state);
    end
    cp_read(ADDR_PKT_COUNT, d);
    n_cmp++;
    if (d !== 32'd4) begin
      n_bad++; $display("FAIL bp_pkt_count got %0d want 4", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    int k;
    bit hit;
    cp_write(ADDR_SPP, 32'd8);
    cp_write(ADDR_NUM_PKTS, 32'd0);
    cp_write(ADDR_CTRL, 32'h1);
    in_tvalid = 1'b1; ip_tready = 1'b1;
    ipo_tvalid = 1'b1; out_tready = 1'b1;
    k = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      #1;
      if (out_tvalid && out_tready) k++;
      if (k == 3) begin
        rst = 1'b1;
        hit = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    n_cmp++;
    if (hit !== 1'b1) begin
      n_bad++; $display("FAIL mrst_reach got %0d beats want 3", k);
    end
    n_cmp++;
    if ({in_tready, ip_tvalid, ipo_tready, out_tvalid, resp_ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL mrst_outputs got %b want 00000",
               {in_tready, ip_tvalid, ipo_tready, out_tvalid, resp_ack});
    end
    ipo_tvalid = 1'b0;
    cp_read(ADDR_SPP, d);
    n_cmp++;
    if (d !== 32'd256) begin
      n_bad++; $display("FAIL mrst_spp got %h want 100", d);
    end
    cp_read(ADDR_STATUS, d);
    n_cmp++;
    if (d[1:0] !== 2'd0) begin
      n_bad++; $display("FAIL mrst_state got %0d want 0", d[1:0]);
    end
    cp_read(ADDR_PKT_COUNT, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_bad++; $display("FAIL mrst_pkt_count got %0d want 0", d);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_wr = 1'b0; req_rd = 1'b0; req_addr = '0; req_data = '0;
    in_tdata = 32'hA5A5_0000; in_tvalid = 1'b0; in_ts = '0; in_ht = 1'b0;
    ip_tready = 1'b0; ipo_tdata = '0; ipo_tvalid = 1'b0; out_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_regs();
    test_spp_err();
    test_frames();
    test_stop();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
